// File: rtl/uart_loader.sv
// UART boot programmer: receives an 8N1 byte stream (16-bit word count, then
// little-endian 32-bit words) and writes the words sequentially through the upg_* port.
module uart_loader #(
  parameter int CLK_HZ      = 23_000_000,
  parameter int BAUD        = 128_000,
  parameter int TIMEOUT_CYC = 2_300_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  output logic        upg_wen_o,
  output logic [14:0] upg_adr_o,
  output logic [31:0] upg_dat_o,
  output logic        upg_done_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CPB = CLK_HZ / BAUD;
  localparam int BW  = $clog2(CPB + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {LD_HDR0, LD_HDR1, LD_WORD, LD_DONE} ld_state_t;

  // RX front end
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      sh_q, sh_d;
  logic            byte_vld, frm_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      sh_q       <= '0;
    end else begin
      rx_s1_q    <= rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      sh_q       <= sh_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    sh_d       = sh_q;
    byte_vld   = 1'b0;
    frm_err    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_s3_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          baud_d     = '0;
        end
      end
      RX_START: begin
        // Half a bit in: a high line here means the falling edge was a glitch.
        if (baud_q == BW'(CPB / 2 - 1)) begin
          baud_d     = '0;
          bit_d      = '0;
          rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == BW'(CPB - 1)) begin
          baud_d = '0;
          sh_d   = {rx_s2_q, sh_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == BW'(CPB - 1)) begin
          baud_d     = '0;
          byte_vld   = rx_s2_q;
          frm_err    = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Loader
  ld_state_t     ld_state_q, ld_state_d;
  logic [15:0]   n_q, n_d, n_new;
  logic [15:0]   k_q, k_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [31:0]   word_q, word_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;
  logic          wen_q, wen_d;
  logic [14:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_q <= LD_HDR0;
      n_q        <= '0;
      k_q        <= '0;
      bcnt_q     <= '0;
      word_q     <= '0;
      tmo_q      <= '0;
      wen_q      <= 1'b0;
      adr_q      <= '0;
      dat_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      ld_state_q <= ld_state_d;
      n_q        <= n_d;
      k_q        <= k_d;
      bcnt_q     <= bcnt_d;
      word_q     <= word_d;
      tmo_q      <= tmo_d;
      wen_q      <= wen_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    ld_state_d = ld_state_q;
    n_d        = n_q;
    n_new      = {sh_q, n_q[7:0]};
    k_d        = k_q;
    bcnt_d     = bcnt_q;
    word_d     = word_q;
    wen_d      = 1'b0;
    adr_d      = adr_q;
    dat_d      = dat_q;
    done_d     = done_q | (ld_state_q == LD_DONE);
    err_d      = err_q;
    tmo_d      = '0;
    timeout    = 1'b0;
    // Idle watchdog only runs mid-session; a byte in the same cycle wins.
    if ((ld_state_q == LD_HDR1 || ld_state_q == LD_WORD) && !byte_vld) begin
      tmo_d   = tmo_q + TW'(1);
      timeout = (tmo_q == TW'(TIMEOUT_CYC - 1));
    end
    case (ld_state_q)
      LD_HDR0: begin
        if (byte_vld) begin
          n_d[7:0]   = sh_q;
          ld_state_d = LD_HDR1;
        end else if (frm_err) begin
          err_d = 1'b1;
        end
      end
      LD_HDR1: begin
        if (byte_vld) begin
          n_d = n_new;
          if (n_new == 16'd0) begin
            ld_state_d = LD_DONE;
          end else if (n_new > 16'd32768) begin
            err_d      = 1'b1;
            ld_state_d = LD_HDR0;
          end else begin
            k_d        = '0;
            bcnt_d     = '0;
            ld_state_d = LD_WORD;
          end
        end else if (frm_err || timeout) begin
          err_d      = 1'b1;
          ld_state_d = LD_HDR0;
        end
      end
      LD_WORD: begin
        if (byte_vld) begin
          word_d = {sh_q, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wen_d = 1'b1;
            adr_d = k_q[14:0];
            dat_d = {sh_q, word_q[31:8]};
            k_d   = k_q + 16'd1;
            if (k_q + 16'd1 == n_q) ld_state_d = LD_DONE;
          end
        end else if (frm_err || timeout) begin
          err_d      = 1'b1;
          k_d        = '0;
          bcnt_d     = '0;
          ld_state_d = LD_HDR0;
        end
      end
      LD_DONE: ld_state_d = LD_DONE;
      default: ld_state_d = LD_HDR0;
    endcase
  end

  assign upg_wen_o  = wen_q;
  assign upg_adr_o  = adr_q;
  assign upg_dat_o  = dat_q;
  assign upg_done_o = done_q;
  assign busy_o     = (ld_state_q == LD_WORD);
  assign err_o      = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader with CPB=10 and a 200-cycle idle timeout.
module tb_uart_loader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_i = 1'b1;
  logic        upg_wen_o;
  logic [14:0] upg_adr_o;
  logic [31:0] upg_dat_o;
  logic        upg_done_o, busy_o, err_o;

  uart_loader #(.CLK_HZ(1000), .BAUD(100), .TIMEOUT_CYC(200)) dut (
    .clk(clk), .rst(rst), .rx_i(rx_i),
    .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
    .upg_done_o(upg_done_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int wcnt = 0;
  logic wen_prev = 1'b0;
  logic done_at_wen = 1'b0;
  logic done_after = 1'b0;
  logic [14:0] adr_log [16];
  logic [31:0] dat_log [16];

  // Write-strobe monitor
  always @(negedge clk) begin
    if (wen_prev) done_after <= upg_done_o;
    wen_prev <= upg_wen_o;
    if (upg_wen_o) begin
      adr_log[wcnt % 16] <= upg_adr_o;
      dat_log[wcnt % 16] <= upg_dat_o;
      done_at_wen        <= upg_done_o;
      wcnt               <= wcnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(10);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx_i = 1'b1;
    tick(6);
  endtask

  task automatic apply_reset();
    rst  = 1'b1;
    rx_i = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    int base;
    // Reset with line noise
    rst = 1'b1;
    base = wcnt;
    tick(1);
    for (int i = 0; i < 24; i++) begin
      rx_i = (i % 3 == 0);
      tick(1);
    end
    rx_i = 1'b1;
    tick(3);
    check("rst_wen", 32'(upg_wen_o), 32'd0);
    check("rst_adr", 32'(upg_adr_o), 32'd0);
    check("rst_dat", upg_dat_o, 32'd0);
    check("rst_done", 32'(upg_done_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_noise_wen", 32'(wcnt - base), 32'd0);
    rst = 1'b0;
    tick(2);

    // Two-word image
    base = wcnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    check("hdr_busy", 32'(busy_o), 32'd1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check("w0_adr", 32'(adr_log[base % 16]), 32'd0);
    check("w0_dat", dat_log[base % 16], 32'h12345678);
    check("w0_hold_dat", upg_dat_o, 32'h12345678);
    check("w0_done", 32'(upg_done_o), 32'd0);
    send_byte(8'hEF, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hDE, 1'b1);
    tick(2);
    check("w2_count", 32'(wcnt - base), 32'd2);
    check("w1_adr", 32'(adr_log[(base + 1) % 16]), 32'd1);
    check("w1_dat", dat_log[(base + 1) % 16], 32'hDEADBEEF);
    check("w1_done_at_wen", 32'(done_at_wen), 32'd0);
    check("w1_done_next", 32'(done_after), 32'd1);
    check("w2_busy", 32'(busy_o), 32'd0);
    check("w2_err", 32'(err_o), 32'd0);

    // Empty image, trailing bytes ignored
    apply_reset();
    check("rst2_done", 32'(upg_done_o), 32'd0);
    base = wcnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    check("n0_done", 32'(upg_done_o), 32'd1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    check("n0_wen", 32'(wcnt - base), 32'd0);
    check("n0_busy", 32'(busy_o), 32'd0);
    check("n0_done_hold", 32'(upg_done_o), 32'd1);

    // Framing error mid-word, then recovery
    apply_reset();
    base = wcnt;
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h9A, 1'b0);
    check("fe_err", 32'(err_o), 32'd1);
    check("fe_busy", 32'(busy_o), 32'd0);
    check("fe_wen", 32'(wcnt - base), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("fe_rec_count", 32'(wcnt - base), 32'd1);
    check("fe_rec_adr", 32'(adr_log[base % 16]), 32'd0);
    check("fe_rec_dat", dat_log[base % 16], 32'h44332211);
    check("fe_rec_done", 32'(upg_done_o), 32'd1);

    // Glitch rejection, oversized header
    apply_reset();
    base = wcnt;
    rx_i = 1'b0;
    tick(3);
    rx_i = 1'b1;
    tick(20);
    check("glitch_busy", 32'(busy_o), 32'd0);
    check("glitch_err", 32'(err_o), 32'd0);
    send_byte(8'h01, 1'b1);
    send_byte(8'h80, 1'b1);
    check("big_err", 32'(err_o), 32'd1);
    check("big_busy", 32'(busy_o), 32'd0);
    check("big_wen", 32'(wcnt - base), 32'd0);

    // Idle timeout mid-word
    apply_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    check("to_pre_busy", 32'(busy_o), 32'd1);
    check("to_pre_err", 32'(err_o), 32'd0);
    tick(250);
    check("to_err", 32'(err_o), 32'd1);
    check("to_busy", 32'(busy_o), 32'd0);

    // Reset mid-word after one write
    apply_reset();
    base = wcnt;
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h55, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    check("mid_pre_dat", upg_dat_o, 32'h44332211);
    rst = 1'b1;
    tick(2);
    rx_i = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("mid_adr", 32'(upg_adr_o), 32'd0);
    check("mid_dat", upg_dat_o, 32'd0);
    check("mid_busy", 32'(busy_o), 32'd0);
    check("mid_done", 32'(upg_done_o), 32'd0);
    check("mid_wen", 32'(wcnt - base), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
